// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel-enable strobes, sync, blanking and position
// counters for the line-doubler input side. Geometry is fixed by parameters;
// res_sel picks how many ce_pix strobes form one real pixel.
module video_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_TOTAL  = 456,
  parameter int unsigned H_ACTIVE = 320,
  parameter int unsigned HS_START = 352,
  parameter int unsigned HS_LEN   = 32,
  parameter int unsigned V_TOTAL  = 312,
  parameter int unsigned V_ACTIVE = 240,
  parameter int unsigned VS_START = 270,
  parameter int unsigned VS_LEN   = 3
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [1:0]  res_sel,
  output logic        ce_pix,
  output logic        ce_pix_actual,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        hblank,
  output logic        vblank,
  output logic        de,
  output logic [10:0] hcnt,
  output logic [9:0]  vcnt,
  output logic        frame_start
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned HW    = 11;
  localparam int unsigned VW    = 10;

  logic [DIV_W-1:0] r_div_cnt;
  logic [HW-1:0]    r_nh;
  logic [VW-1:0]    r_nv;
  logic [1:0]       r_phase;
  logic [1:0]       r_div_lat;

  logic             w_emit;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_line_first;
  logic [1:0]       w_eff_phase;
  logic [1:0]       w_new_lat;
  logic [1:0]       w_phase_mask;
  logic [1:0]       w_next_phase;
  logic             w_hblank;
  logic             w_vblank;
  logic             w_hs;
  logic             w_vs;

  assign w_emit       = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_h_last     = (r_nh == HW'(H_TOTAL - 1));
  assign w_v_last     = (r_nv == VW'(V_TOTAL - 1));
  assign w_line_first = (r_nh == HW'(0));

  // Decode of the position about to be emitted
  assign w_hblank = (r_nh >= HW'(H_ACTIVE));
  assign w_vblank = (r_nv >= VW'(V_ACTIVE));
  assign w_hs     = (r_nh >= HW'(HS_START)) && (r_nh < HW'(HS_START + HS_LEN));
  assign w_vs     = (r_nv >= VW'(VS_START)) && (r_nv < VW'(VS_START + VS_LEN));

  // Phase restarts at each line so the first pixel is always an actual one;
  // the divide latched at that same emit governs the rest of the line.
  always_comb begin
    w_eff_phase  = w_line_first ? 2'd0 : r_phase;
    w_new_lat    = w_line_first ? res_sel : r_div_lat;
    w_phase_mask = 2'd3;
    case (w_new_lat)
      2'd0:    w_phase_mask = 2'd0;
      2'd1:    w_phase_mask = 2'd1;
      default: w_phase_mask = 2'd3;
    endcase
    w_next_phase = (w_eff_phase + 2'd1) & w_phase_mask;
  end

  // Base clock divider
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (w_emit) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Next-position pointer, resolution phase and latched divide
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_nh      <= '0;
      r_nv      <= '0;
      r_phase   <= '0;
      r_div_lat <= '0;
    end else if (w_emit) begin
      r_phase   <= w_next_phase;
      r_div_lat <= w_new_lat;
      if (w_h_last) begin
        r_nh <= '0;
        r_nv <= w_v_last ? VW'(0) : r_nv + VW'(1);
      end else begin
        r_nh <= r_nh + HW'(1);
      end
    end
  end

  // Registered outputs: strobes pulse for one cycle, the rest load at emits
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ce_pix        <= 1'b0;
      ce_pix_actual <= 1'b0;
      frame_start   <= 1'b0;
      hs            <= 1'b0;
      vs            <= 1'b0;
      line_start    <= 1'b0;
      hblank        <= 1'b0;
      vblank        <= 1'b0;
      de            <= 1'b0;
      hcnt          <= '0;
      vcnt          <= '0;
    end else begin
      ce_pix        <= w_emit;
      ce_pix_actual <= w_emit && (w_eff_phase == 2'd0);
      frame_start   <= w_emit && w_line_first && (r_nv == VW'(0));
      if (w_emit) begin
        hs         <= w_hs;
        vs         <= w_vs;
        line_start <= w_hblank;
        hblank     <= w_hblank;
        vblank     <= w_vblank;
        de         <= !w_hblank && !w_vblank;
        hcnt       <= r_nh;
        vcnt       <= r_nv;
      end
    end
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Generates the raster timing and pixel-enable strobes that feed the line-doubling stage on its input side. It provides ce_pix, ce_pix_actual, hs, vs and line_start, plus blanking, data-enable and position counters for the pixel source. The whole frame geometry is set by parameters. A run-time resolution select chooses how many base ce_pix strobes make up one real pixel (1, 2 or 4). All logic runs on clk_sys.

Parameters:
CLK_DIV, 4, clk_sys cycles per ce_pix strobe (2..16)
H_TOTAL, 456, ce_pix periods per line
H_ACTIVE, 320, active ce_pix periods per line, starting at hcnt 0
HS_START, 352, hcnt at which hs asserts
HS_LEN, 32, hs width in ce_pix periods
V_TOTAL, 312, lines per frame
V_ACTIVE, 240, active lines, starting at vcnt 0
VS_START, 270, vcnt at which vs asserts
VS_LEN, 3, vs width in lines

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous active-high reset
res_sel  in  2  pixel divide: 0 = /1, 1 = /2, 2 = /4, 3 = /4
ce_pix  out  1  one-clk_sys strobe every CLK_DIV cycles
ce_pix_actual  out  1  ce_pix qualified to the first strobe of each real pixel
hs  out  1  horizontal sync, active high
vs  out  1  vertical sync, active high
line_start  out  1  high during horizontal blanking; its falling edge marks the first active pixel
hblank  out  1  hcnt >= H_ACTIVE
vblank  out  1  vcnt >= V_ACTIVE
de  out  1  ~hblank & ~vblank
hcnt  out  11  emitted horizontal position
vcnt  out  10  emitted line number
frame_start  out  1  pulse with ce_pix when position (0,0) is emitted

Behaviour:
- Clock and reset: one clock, clk_sys. reset is synchronous and active-high.
- Reset: div_cnt=0, next-position pointer (nh,nv)=(0,0), phase=0, div_lat=0.
- Outputs held at 0 during reset: ce_pix, ce_pix_actual, hs, vs, line_start, hblank, vblank, de, hcnt, vcnt, frame_start.
- Reset mid-frame aborts immediately. No partial sync pulse is stretched.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps.
- Emit event: when div_cnt==CLK_DIV-1 at a clock edge, the registered outputs load the decode of (nh,nv) and ce_pix=1 for exactly the following cycle. ce_pix is 0 in all other cycles.
- First ce_pix after reset release: exactly CLK_DIV cycles after release, emitting (0,0) with frame_start=1.
- All outputs are registered. They change only at emit edges, except ce_pix, ce_pix_actual and frame_start, which are single-cycle pulses.
- Position advance at each emit:
  - nh increments.
  - If nh==H_TOTAL-1: nh wraps to 0 and nv increments.
  - If nv==V_TOTAL-1 at that wrap: nv wraps to 0.
- Decode:
  - hs = HS_START <= h < HS_START+HS_LEN.
  - vs = VS_START <= v < VS_START+VS_LEN. vs changes only on emits with h==0.
  - line_start = hblank.
- Resolution phase:
  - phase counts emits modulo N, where N = 1, 2 or 4 from the latched div_lat.
  - ce_pix_actual = ce_pix & (phase==0).
  - phase is forced to 0 on every emit with h==0, so the first pixel of each line is always actual.
- res_sel latch: res_sel is latched into div_lat only on emits with h==0. A mid-line change takes effect at the next line. This guarantees a constant divide within a line.
- Geometry: parameters are assumed legal, i.e. H_ACTIVE < HS_START and HS_START+HS_LEN <= H_TOTAL; likewise for the vertical parameters. No run-time checking.
- Widths: hcnt is 11 bits and vcnt is 10 bits. Parameters must fit; no overflow handling is needed.

Test Plan:
Test parameters: CLK_DIV=4, H_TOTAL=16, H_ACTIVE=10, HS_START=12, HS_LEN=2, V_TOTAL=8, V_ACTIVE=5, VS_START=6, VS_LEN=1.
- Reset release: deassert reset at cycle 0 -> ce_pix first high at cycle 4 with hcnt=0, vcnt=0, de=1, frame_start=1. Thereafter ce_pix high every 4th cycle only.
- Line timing: run one line -> hblank and line_start rise at hcnt=10, hs high for hcnt 12..13, hcnt wraps 15->0 with vcnt 0->1, line_start falls at hcnt=0.
- Frame timing: run one frame -> vblank high for vcnt 5..7, vs high only during vcnt=6, frame_start once per 128 ce_pix, vcnt wraps 7->0.
- Resolution select: res_sel=1 -> ce_pix_actual on hcnt 0,2,4,...,14. Switch res_sel to 2 at hcnt=5 -> current line unchanged; next line ce_pix_actual on hcnt 0,4,8,12.
- Reset mid-frame: assert reset at vcnt=6 while hs=1 -> next edge all outputs 0. After release, first emit is (0,0) 4 cycles later.
- res_sel=3: behaves identically to res_sel=2 (every 4th ce_pix).
